// File: rtl/vsum_job_arbiter_pkg.sv
// Shared types for the vector-sum job arbiter and the vectorsum top-level integration.
package vsum_job_arbiter_pkg;

    localparam int LEN_WIDTH_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } vsum_state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: on contention the requester that did not win last goes first.
module rr_arb2 (
    input  logic req_0,
    input  logic req_1,
    input  logic last,
    output logic any,
    output logic pick
);

    always_comb begin
        any  = req_0 | req_1;
        pick = (req_0 & req_1) ? ~last : req_1;
    end

endmodule

// File: rtl/vsum_job_arbiter.sv
// Grants the shared vector-sum datapath to one of two requesters for a whole job and
// counts result beats down to completion.
module vsum_job_arbiter
    import vsum_job_arbiter_pkg::*;
#(
    parameter int LEN_WIDTH = LEN_WIDTH_DEF
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 req_0,
    input  logic                 req_1,
    input  logic [LEN_WIDTH-1:0] len_0,
    input  logic [LEN_WIDTH-1:0] len_1,
    input  logic                 beat,
    output logic                 gnt_0,
    output logic                 gnt_1,
    output logic                 sel,
    output logic                 busy,
    output logic [LEN_WIDTH-1:0] remaining,
    output logic                 done_0,
    output logic                 done_1
);

    vsum_state_e state;
    logic        last;
    logic        any_req;
    logic        pick;

    rr_arb2 u_rr_arb2 (
        .req_0 (req_0),
        .req_1 (req_1),
        .last  (last),
        .any   (any_req),
        .pick  (pick)
    );

    // last resets to 1 so requester 0 wins the first contended pick
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            sel       <= 1'b0;
            remaining <= '0;
            last      <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        state     <= ST_RUN;
                        sel       <= pick;
                        remaining <= pick ? len_1 : len_0;
                    end
                end
                ST_RUN: begin
                    // zero-length jobs finish without beats; the counter never wraps
                    if (remaining == '0) begin
                        state <= ST_DONE;
                    end else if (beat) begin
                        remaining <= remaining - 1'b1;
                        if (remaining == LEN_WIDTH'(1))
                            state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    last  <= sel;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        busy   = (state == ST_RUN);
        gnt_0  = busy & ~sel;
        gnt_1  = busy &  sel;
        done_0 = (state == ST_DONE) & ~sel;
        done_1 = (state == ST_DONE) &  sel;
    end

endmodule

// File: tb/tb_vsum_job_arbiter.sv
// Directed bench for vsum_job_arbiter with hand-computed expectations and running protocol checks.
module tb_vsum_job_arbiter;

    localparam int LW = 16;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          req_0 = 1'b0, req_1 = 1'b0, beat = 1'b0;
    logic [LW-1:0] len_0 = '0, len_1 = '0;
    logic          gnt_0, gnt_1, sel, busy, done_0, done_1;
    logic [LW-1:0] remaining;

    int checks = 0;
    int errors = 0;

    vsum_job_arbiter #(.LEN_WIDTH(LW)) dut (
        .clock     (clock),
        .reset     (reset),
        .req_0     (req_0),
        .req_1     (req_1),
        .len_0     (len_0),
        .len_1     (len_1),
        .beat      (beat),
        .gnt_0     (gnt_0),
        .gnt_1     (gnt_1),
        .sel       (sel),
        .busy      (busy),
        .remaining (remaining),
        .done_0    (done_0),
        .done_1    (done_1)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // exp = {gnt_0, gnt_1, busy, sel, done_0, done_1}
    task automatic chk(input string tag, input logic [5:0] exp, input int rem);
        logic [5:0] obs;
        obs = {gnt_0, gnt_1, busy, sel, done_0, done_1};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s outs obs=%b exp=%b", tag, obs, exp);
        end
        checks++;
        assert (remaining === LW'(rem)) else begin
            errors++;
            $error("FAIL %s remaining obs=%0d exp=%0d", tag, remaining, rem);
        end
    endtask

    localparam logic [5:0] O_IDLE0 = 6'b000000;
    localparam logic [5:0] O_IDLE1 = 6'b000100;
    localparam logic [5:0] O_RUN0  = 6'b101000;
    localparam logic [5:0] O_RUN1  = 6'b011100;
    localparam logic [5:0] O_DONE0 = 6'b000010;
    localparam logic [5:0] O_DONE1 = 6'b000101;

    // Running protocol checks sampled mid-cycle
    logic          prev_done = 1'b0, prev_busy = 1'b0;
    logic [LW-1:0] prev_rem = '0;
    always @(negedge clock) begin
        if (!reset) begin
            prev_done = 1'b0;
            prev_busy = 1'b0;
            prev_rem  = '0;
        end else begin
            checks++;
            assert (!(gnt_0 && gnt_1)) else begin
                errors++;
                $error("FAIL gnt_onehot obs=%b%b exp=not-both", gnt_0, gnt_1);
            end
            checks++;
            assert (!(prev_done && (done_0 || done_1))) else begin
                errors++;
                $error("FAIL done_twice obs=%b%b exp=00", done_0, done_1);
            end
            if (prev_busy && busy) begin
                checks++;
                assert (remaining <= prev_rem) else begin
                    errors++;
                    $error("FAIL rem_grow obs=%0d exp<=%0d", remaining, prev_rem);
                end
            end
            prev_done = done_0 | done_1;
            prev_busy = busy;
            prev_rem  = remaining;
        end
    end

    initial begin
        // reset state
        #2;
        chk("reset", O_IDLE0, 0);
        tick();
        reset = 1'b1;

        // single job, len 4, consecutive beats
        req_0 = 1'b1; len_0 = 16'd4;
        tick(); chk("s1_grant", O_RUN0, 4);
        req_0 = 1'b0; beat = 1'b1;
        tick(); chk("s1_r3", O_RUN0, 3);
        tick(); chk("s1_r2", O_RUN0, 2);
        tick(); chk("s1_r1", O_RUN0, 1);
        tick(); chk("s1_done", O_DONE0, 0);
        beat = 1'b0;
        tick(); chk("s1_idle", O_IDLE0, 0);

        // zero-length job on requester 1
        req_1 = 1'b1; len_1 = 16'd0;
        tick(); chk("s3_grant", O_RUN1, 0);
        req_1 = 1'b0;
        tick(); chk("s3_done", O_DONE1, 0);
        tick(); chk("s3_idle", O_IDLE1, 0);

        // both requesting, held: grants alternate 0,1,0,1
        req_0 = 1'b1; req_1 = 1'b1; len_0 = 16'd2; len_1 = 16'd3; beat = 1'b1;
        tick(); chk("s2_a_grant", O_RUN0, 2);
        tick(); chk("s2_a_r1",    O_RUN0, 1);
        tick(); chk("s2_a_done",  O_DONE0, 0);
        tick(); chk("s2_a_idle",  O_IDLE0, 0);
        tick(); chk("s2_b_grant", O_RUN1, 3);
        tick(); chk("s2_b_r2",    O_RUN1, 2);
        tick(); chk("s2_b_r1",    O_RUN1, 1);
        tick(); chk("s2_b_done",  O_DONE1, 0);
        tick(); chk("s2_b_idle",  O_IDLE1, 0);
        tick(); chk("s2_c_grant", O_RUN0, 2);
        tick(); chk("s2_c_r1",    O_RUN0, 1);
        tick(); chk("s2_c_done",  O_DONE0, 0);
        tick(); chk("s2_c_idle",  O_IDLE0, 0);
        tick(); chk("s2_d_grant", O_RUN1, 3);
        req_0 = 1'b0; req_1 = 1'b0;
        tick(); chk("s2_d_r2",    O_RUN1, 2);
        tick(); chk("s2_d_r1",    O_RUN1, 1);
        tick(); chk("s2_d_done",  O_DONE1, 0);
        tick(); chk("s2_d_idle",  O_IDLE1, 0);

        // len 5 with toggling beat; len changes after grant are ignored
        beat = 1'b0; req_0 = 1'b1; len_0 = 16'd5;
        tick(); chk("s4_grant", O_RUN0, 5);
        req_0 = 1'b0; len_0 = 16'd9;
        beat = 1'b1; tick(); chk("s4_b1", O_RUN0, 4);
        beat = 1'b0; tick(); chk("s4_g1", O_RUN0, 4);
        beat = 1'b1; tick(); chk("s4_b2", O_RUN0, 3);
        beat = 1'b0; tick(); chk("s4_g2", O_RUN0, 3);
        beat = 1'b1; tick(); chk("s4_b3", O_RUN0, 2);
        beat = 1'b0; tick(); chk("s4_g3", O_RUN0, 2);
        beat = 1'b1; tick(); chk("s4_b4", O_RUN0, 1);
        beat = 1'b0; tick(); chk("s4_g4", O_RUN0, 1);
        beat = 1'b1; tick(); chk("s4_done", O_DONE0, 0);
        tick(); chk("s4_idle", O_IDLE0, 0);
        tick(); chk("s4_idle_beat", O_IDLE0, 0);

        // reset asserted mid-job
        beat = 1'b0; req_0 = 1'b1; len_0 = 16'd6;
        tick(); chk("s5_grant", O_RUN0, 6);
        req_0 = 1'b0; beat = 1'b1;
        tick(); chk("s5_r5", O_RUN0, 5);
        tick(); chk("s5_r4", O_RUN0, 4);
        tick(); chk("s5_r3", O_RUN0, 3);
        #2 reset = 1'b0;
        #1 chk("s5_async_rst", O_IDLE0, 0);
        tick(); chk("s5_rst_hold", O_IDLE0, 0);
        reset = 1'b1; beat = 1'b0;
        req_1 = 1'b1; len_1 = 16'd2;
        tick(); chk("s5_regrant", O_RUN1, 2);
        req_1 = 1'b0; beat = 1'b1;
        tick(); chk("s5_r1", O_RUN1, 1);
        tick(); chk("s5_done", O_DONE1, 0);
        beat = 1'b0;
        tick(); chk("s5_idle", O_IDLE1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vsum_job_arbiter.md
VSUM_JOB_ARBITER -- requirements
Module: vsum_job_arbiter

Interface
REQ-001 Parameter LEN_WIDTH, default 16, width of job length and remaining count.
REQ-002 clock  in  1  rising-edge system clock.
REQ-003 reset  in  1  asynchronous, active-low.
REQ-004 req_0, req_1  in  1 each  requester N wants one vector-sum job on the shared streaming datapath.
REQ-005 len_0, len_1  in  LEN_WIDTH each  element count of requester N's job; sampled only at grant.
REQ-006 beat  in  1  datapath transferred one result element for the current job this cycle.
REQ-007 gnt_0, gnt_1  out  1 each  one-hot grant, held for the entire job.
REQ-008 sel  out  1  source-mux select for x/y/z streams: 0 = requester 0, 1 = requester 1; valid while busy.
REQ-009 busy  out  1  high in RUN state.
REQ-010 remaining  out  LEN_WIDTH  elements still owed on the current job.
REQ-011 done_0, done_1  out  1 each  single-cycle completion pulse to requester N.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, RUN, DONE.
REQ-013 IDLE: if req_0 or req_1 is high at a rising edge, the block SHALL pick a winner, latch its len into remaining, record it in sel, and enter RUN on that edge.
REQ-014 Winner selection SHALL be round-robin: with both requesting, the requester that did not win last SHALL win; after reset requester 0 has priority.
REQ-015 RUN: gnt_<sel> SHALL be high and the other grant low; busy SHALL be high.
REQ-016 RUN: each cycle with beat=1 SHALL decrement remaining by 1.
REQ-017 RUN: when beat=1 and remaining==1, the block SHALL enter DONE on that edge, with remaining reaching 0.
REQ-018 A job latched with len==0 SHALL enter RUN and then go to DONE on the next edge regardless of beat; remaining SHALL never wrap below 0.
REQ-019 DONE: done_<sel> SHALL pulse high for exactly one cycle and both grants SHALL be low; the last-winner pointer SHALL update; next state IDLE.
REQ-020 beat SHALL be ignored in IDLE and DONE.
REQ-021 req SHALL be ignored outside IDLE; a req still high in IDLE after DONE SHALL be treated as a new job, subject to round-robin.
REQ-022 Latency: req high at edge k gives grant visible after edge k; the DONE pulse appears one cycle after the final beat edge; minimum request-to-request turnaround is 3 cycles.
REQ-023 All outputs SHALL be registered, or decoded from registered state only, with no combinational path from inputs.

Reset
REQ-024 On reset low, the block SHALL go asynchronously to IDLE with gnt_0=gnt_1=0, done_0=done_1=0, busy=0, sel=0, remaining=0, and last-winner = 1 (so requester 0 wins first).
REQ-025 Reset asserted mid-job SHALL abort the job immediately with no done pulse; after release, operation starts from IDLE.

Structure
REQ-026 A shared package SHALL hold the state enum type (IDLE/RUN/DONE) and the default LEN_WIDTH constant; it is shared with the vectorsum top-level integration.
REQ-027 One sub-module, rr_arb2 (combinational two-way round-robin pick from request pair and last-winner), SHALL be instantiated; all other logic lives in vsum_job_arbiter.

Verification
REQ-028 Reset released; req_0=1, len_0=4; 4 beats on consecutive cycles -> gnt_0 for 4 cycles; remaining steps 4,3,2,1,0; one done_0 pulse; gnt_1 never high.
REQ-029 req_0 and req_1 high together, len_0=2, len_1=3, reqs held -> grant order 0,1,0,1; done pulses alternate; one grant at most in any cycle.
REQ-030 req_1=1, len_1=0 -> RUN for one cycle, then done_1 pulse, no beats needed, remaining stays 0.
REQ-031 Job len_0=5 with beat toggling 1,0,1,0,... -> done_0 only after the fifth beat; beats in IDLE/DONE leave remaining unchanged.
REQ-032 reset driven low during RUN with remaining=3 -> all outputs reach their reset values without waiting for a clock; no done pulse; a fresh req_1 after release is granted normally.
REQ-033 Assertions, enabled throughout all scenarios: gnt one-hot-or-zero; done never high in two consecutive cycles; remaining never increases during RUN.
